ram_capture_check: RTL

Downstream sink for the ROM→RAM delay-copy stage. It captures every `write_en`/`ram_addr`/`rom_data` beat into a 16×8 register-file RAM and tracks which addresses have been written. On a start/done handshake it reads all 16 words back in address order, streams them out, and compares each against an arithmetic expected pattern. It reports the error count and the first failing address.

---
 rtl/delay_pkg.sv | 33 +++
 rtl/capture_ram.sv | 65 ++++++
 rtl/ram_capture_check.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/delay_pkg.sv
// -----------------------------------------------------------------------------
// delay_pkg
// Shared definitions for the ROM->RAM delay-copy checker slice.
//   DATA_W / ADDR_W : word and address widths of the capture RAM
//   DEPTH           : number of words (2^ADDR_W)
//   state_t         : checker FSM encoding (IDLE/RUN/DRAIN/DONE)
//   exp_val()       : arithmetic expected pattern, base + addr*step, wrapping
// -----------------------------------------------------------------------------
package delay_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // The product is taken in DATA_W bits so the pattern wraps modulo 2^DATA_W.
    function automatic logic [DATA_W-1:0] exp_val(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] base,
        input logic [DATA_W-1:0] step
    );
        logic [DATA_W-1:0] prod;
        prod = DATA_W'(addr) * step;
        return base + prod;
    endfunction

endpackage

// File: rtl/capture_ram.sv
// -----------------------------------------------------------------------------
// capture_ram
// 16x8 register-file RAM plus a per-address "written" mask.
//   clk, rst_n     : clock, asynchronous active-low reset (clears mem and mask)
//   i_wrEn         : write strobe; stores i_wrData at i_wrAddr and marks it
//   i_wrAddr       : write address
//   i_wrData       : write data
//   i_clr          : clears the whole written mask (mem contents are kept)
//   i_rdEn         : registered read enable
//   i_rdAddr       : read address
//   o_rdData       : registered read data
//   o_rdWritten    : registered mask bit of the word read
// -----------------------------------------------------------------------------
module capture_ram
    import delay_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_wrEn,
    input  logic [ADDR_W-1:0] i_wrAddr,
    input  logic [DATA_W-1:0] i_wrData,
    input  logic              i_clr,
    input  logic              i_rdEn,
    input  logic [ADDR_W-1:0] i_rdAddr,
    output logic [DATA_W-1:0] o_rdData,
    output logic              o_rdWritten
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_wmask;
    logic [DATA_W-1:0] r_rdData;
    logic              r_rdWritten;

    // Storage and mask. The write is evaluated after the clear so that a
    // same-cycle write keeps its own mask bit set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem   <= '{default: '0};
            r_wmask <= '0;
        end else begin
            if (i_clr) begin
                r_wmask <= '0;
            end
            if (i_wrEn) begin
                r_mem[i_wrAddr]   <= i_wrData;
                r_wmask[i_wrAddr] <= 1'b1;
            end
        end
    end

    // Registered read port; holds its last value when not enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdData    <= '0;
            r_rdWritten <= 1'b0;
        end else if (i_rdEn) begin
            r_rdData    <= r_mem[i_rdAddr];
            r_rdWritten <= r_wmask[i_rdAddr];
        end
    end

    assign o_rdData    = r_rdData;
    assign o_rdWritten = r_rdWritten;

endmodule

// File: rtl/ram_capture_check.sv
// -----------------------------------------------------------------------------
// ram_capture_check
// Sink for the ROM->RAM delay-copy stage. Captures write beats into a 16x8
// RAM, and on a start/done handshake streams all words back in address order
// while comparing each against base + addr*step.
//   clk, rst_n      : clock, asynchronous active-low reset
//   write_en        : capture strobe (ignored while busy)
//   ram_addr        : capture address
//   rom_data        : capture data
//   clr_sig         : clears the written mask (ignored while busy)
//   start_sig       : check request, held until done_sig
//   done_sig        : one-cycle completion pulse
//   busy            : check in progress
//   rd_valid        : readback beat valid
//   rd_addr         : readback address
//   rd_data         : readback data
//   err_cnt         : number of failing words (mismatch or unwritten), 0..16
//   err_flag        : err_cnt != 0
//   first_err_addr  : lowest failing address, 0 if none
// -----------------------------------------------------------------------------
module ram_capture_check #(
    parameter int                        DATA_W   = delay_pkg::DATA_W,
    parameter int                        ADDR_W   = delay_pkg::ADDR_W,
    parameter logic [delay_pkg::DATA_W-1:0] EXP_BASE = 8'h00,
    parameter logic [delay_pkg::DATA_W-1:0] EXP_STEP = 8'h01
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              clr_sig,
    input  logic              start_sig,
    output logic              done_sig,
    output logic              busy,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W:0]   err_cnt,
    output logic              err_flag,
    output logic [ADDR_W-1:0] first_err_addr
);

    import delay_pkg::*;

    state_t            r_state;
    logic [ADDR_W-1:0] r_rdPtr;
    logic              r_busy;
    logic              r_done;
    logic              r_rdValid;
    logic [ADDR_W-1:0] r_rdAddr;
    logic [ADDR_W:0]   r_errCnt;
    logic [ADDR_W-1:0] r_firstErr;

    logic              w_idle;
    logic              w_ramWrEn;
    logic              w_ramClr;
    logic              w_ramRdEn;
    logic [DATA_W-1:0] w_rdData;
    logic              w_rdWritten;
    logic              w_startCheck;
    logic              w_wordFail;

    // Captures and mask clears are only accepted while no check is running,
    // so the readback sees a frozen snapshot of the RAM.
    assign w_idle       = (r_state == IDLE);
    assign w_ramWrEn    = write_en & w_idle;
    assign w_ramClr     = clr_sig & w_idle;
    assign w_ramRdEn    = (r_state == RUN);
    assign w_startCheck = w_idle & start_sig;

    capture_ram u_ram (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_wrEn      (w_ramWrEn),
        .i_wrAddr    (ram_addr),
        .i_wrData    (rom_data),
        .i_clr       (w_ramClr),
        .i_rdEn      (w_ramRdEn),
        .i_rdAddr    (r_rdPtr),
        .o_rdData    (w_rdData),
        .o_rdWritten (w_rdWritten)
    );

    // Check sequencer: RUN issues one read per cycle for all 16 addresses,
    // DRAIN lets the last beat reach the compare stage, DONE pulses done_sig.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_rdPtr   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rdValid <= 1'b0;
            r_rdAddr  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_sig) begin
                        r_state <= RUN;
                        r_rdPtr <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                RUN: begin
                    r_rdValid <= 1'b1;
                    r_rdAddr  <= r_rdPtr;
                    r_rdPtr   <= r_rdPtr + ADDR_W'(1);
                    if (r_rdPtr == {ADDR_W{1'b1}}) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    r_rdValid <= 1'b0;
                    r_state   <= DONE;
                end
                DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // A beat fails if its address was never written or its data is off-pattern.
    assign w_wordFail = ~w_rdWritten |
                        (w_rdData != exp_val(r_rdAddr, EXP_BASE, EXP_STEP));

    // Compare stage, one cycle behind each readback beat. Results are cleared
    // when a check starts and then held until the next start. The first
    // failing address is captured while the count is still zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_errCnt   <= '0;
            r_firstErr <= '0;
        end else if (w_startCheck) begin
            r_errCnt   <= '0;
            r_firstErr <= '0;
        end else if (r_rdValid && w_wordFail) begin
            r_errCnt <= r_errCnt + (ADDR_W+1)'(1);
            if (r_errCnt == '0) begin
                r_firstErr <= r_rdAddr;
            end
        end
    end

    assign done_sig       = r_done;
    assign busy           = r_busy;
    assign rd_valid       = r_rdValid;
    assign rd_addr        = r_rdAddr;
    assign rd_data        = w_rdData;
    assign err_cnt        = r_errCnt;
    assign err_flag       = (r_errCnt != '0);
    assign first_err_addr = r_firstErr;

endmodule
